// File: rtl/nibble_add_pkg.sv
// Shared definitions for the nibble adder sequencer.
// Contains the sequencer state encoding, the nibble width and the limits
// for the adder settle time, plus the range check used at elaboration.
package nibble_add_pkg;

    localparam int NIBBLE_W   = 4;
    localparam int SETTLE_MAX = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // The settle counter is 4 bits wide, so 1..15 edges are representable.
    function automatic bit settle_ok(input int n);
        return (n >= 1) && (n <= SETTLE_MAX);
    endfunction

endpackage

// File: rtl/nibble_add_sequencer_if.sv
// Operand and result streams of the nibble adder sequencer.
// in_*  : operand nibble stream (valid/ready), flows into the sequencer.
// out_* : captured result stream (valid/ready), flows out of the sequencer.
// slave  modport: the sequencer side.
// master modport: the producer/consumer side (upstream and downstream).
interface nibble_add_sequencer_if
    import nibble_add_pkg::*;
#(
    parameter int IDX_W = 3
) ();

    logic                in_valid;
    logic                in_ready;
    logic [NIBBLE_W-1:0] in_a;
    logic [NIBBLE_W-1:0] in_b;
    logic                in_first;
    logic                in_last;

    logic                out_valid;
    logic                out_ready;
    logic [NIBBLE_W-1:0] out_sum;
    logic                out_cout;
    logic                out_last;
    logic [IDX_W-1:0]    out_idx;

    modport slave (
        input  in_valid, in_a, in_b, in_first, in_last,
        output in_ready,
        output out_valid, out_sum, out_cout, out_last, out_idx,
        input  out_ready
    );

    modport master (
        output in_valid, in_a, in_b, in_first, in_last,
        input  in_ready,
        input  out_valid, out_sum, out_cout, out_last, out_idx,
        output out_ready
    );

endinterface

// File: rtl/nibble_carry_tracker.sv
// Word-level bookkeeping for the nibble adder sequencer.
// Tracks the carry between nibbles of a word, whether a word is open,
// the nibble index within the word and the sticky protocol-error flag.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   accept       : operand nibble accepted this edge
//   in_first     : accepted nibble is flagged as the first of a word
//   capture      : adder result sampled this edge
//   word_last    : the nibble being captured closes its word
//   cout         : adder carry-out being captured
//   cin_next     : carry-in to load onto the adder on accept
//   idx_q        : index of the nibble currently in flight
//   seq_err      : sticky protocol-error flag
module nibble_carry_tracker #(
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             accept,
    input  logic             in_first,
    input  logic             capture,
    input  logic             word_last,
    input  logic             cout,
    output logic             cin_next,
    output logic [IDX_W-1:0] idx_q,
    output logic             seq_err
);

    logic carry_q;
    logic word_open_q;
    logic start_new;

    // A continuation with no open word is restarted as a fresh word.
    assign start_new = in_first | ~word_open_q;
    assign cin_next  = start_new ? 1'b0 : carry_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_q     <= 1'b0;
            word_open_q <= 1'b0;
            idx_q       <= '0;
            seq_err     <= 1'b0;
        end else begin
            if (accept) begin
                idx_q <= start_new ? '0 : idx_q + 1'b1;
                if (~in_first & ~word_open_q) begin
                    seq_err <= 1'b1;
                end
            end
            if (capture) begin
                carry_q     <= word_last ? 1'b0 : cout;
                word_open_q <= ~word_last;
            end
        end
    end

endmodule

// File: rtl/nibble_add_sequencer.sv
// Sequencer around a 4-bit ripple adder cell.
// Accepts operand nibbles on a valid/ready stream, holds them static on the
// adder pins for SETTLE_CYCLES edges, then captures sum/carry and offers the
// result downstream. Carry is chained across the nibbles of a word.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   bus (slave)         : operand stream in, result stream out
//   a..a_3, b..b_3, cin : adder input pins (registered, change only on accept)
//   S..S_3, cout        : adder output pins
//   seq_err             : sticky protocol-error flag
module nibble_add_sequencer
    import nibble_add_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int IDX_W         = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    nibble_add_sequencer_if.slave       bus,
    output logic                        a,
    output logic                        a_1,
    output logic                        a_2,
    output logic                        a_3,
    output logic                        b,
    output logic                        b_1,
    output logic                        b_2,
    output logic                        b_3,
    output logic                        cin,
    input  logic                        S,
    input  logic                        S_1,
    input  logic                        S_2,
    input  logic                        S_3,
    input  logic                        cout,
    output logic                        seq_err
);

    if (!settle_ok(SETTLE_CYCLES)) begin : g_bad_settle
        $error("nibble_add_sequencer: SETTLE_CYCLES must be 1..15");
    end

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t              state_q;
    state_t              state_d;
    logic [3:0]          cnt_q;
    logic [NIBBLE_W-1:0] a_q;
    logic [NIBBLE_W-1:0] b_q;
    logic                cin_q;
    logic                last_q;
    logic [NIBBLE_W-1:0] sum_q;
    logic                cout_q;
    logic                out_last_q;
    logic [IDX_W-1:0]    out_idx_q;

    logic                accept;
    logic                capture;
    logic                cin_next;
    logic [IDX_W-1:0]    idx_q;

    assign accept  = bus.in_valid & (state_q == IDLE);
    assign capture = (state_q == DRIVE) & (cnt_q == 4'd0);

    nibble_carry_tracker #(
        .IDX_W (IDX_W)
    ) u_tracker (
        .clk       (clk),
        .rst       (rst),
        .accept    (accept),
        .in_first  (bus.in_first),
        .capture   (capture),
        .word_last (last_q),
        .cout      (cout),
        .cin_next  (cin_next),
        .idx_q     (idx_q),
        .seq_err   (seq_err)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)  state_d = DRIVE;
            DRIVE:   if (cnt_q == 4'd0) state_d = HOLD;
            HOLD:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == HOLD);
    end

    // Adder drive pins and settle counter; pins move only on accept so the
    // ripple never sees a change mid-settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            cin_q  <= 1'b0;
            last_q <= 1'b0;
            cnt_q  <= 4'd0;
        end else if (accept) begin
            a_q    <= bus.in_a;
            b_q    <= bus.in_b;
            cin_q  <= cin_next;
            last_q <= bus.in_last;
            cnt_q  <= SETTLE_LOAD;
        end else if ((state_q == DRIVE) && (cnt_q != 4'd0)) begin
            cnt_q  <= cnt_q - 4'd1;
        end
    end

    // Result capture; held unchanged through HOLD
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q      <= '0;
            cout_q     <= 1'b0;
            out_last_q <= 1'b0;
            out_idx_q  <= '0;
        end else if (capture) begin
            sum_q      <= {S_3, S_2, S_1, S};
            cout_q     <= cout;
            out_last_q <= last_q;
            out_idx_q  <= idx_q;
        end
    end

    assign {a_3, a_2, a_1, a} = a_q;
    assign {b_3, b_2, b_1, b} = b_q;
    assign cin                = cin_q;

    assign bus.out_sum  = sum_q;
    assign bus.out_cout = cout_q;
    assign bus.out_last = out_last_q;
    assign bus.out_idx  = out_idx_q;

endmodule
